// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline run controller: FSM states, debug command
// codes and default widths.
package pipeline_ctrl_pkg;

  localparam int unsigned NB_CMD_DEF   = 2;
  localparam int unsigned NB_STATE_DEF = 3;

  typedef enum logic [NB_STATE_DEF-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [NB_CMD_DEF-1:0] {
    CMD_STOP  = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

endpackage

// File: rtl/pipeline_run_controller_sat_counter.sv
// Saturating up-counter with enable, synchronous clear (priority over enable)
// and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_run_controller.sv
// Debug-path run/step/stop/flush sequencer driving the global pipeline enable.
// Optional enabled-cycle counter is built only when PIPE_CYCLE_COUNT_EN is defined.
module pipeline_run_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB_CMD       = NB_CMD_DEF,
  parameter int unsigned NB_CYCLES    = 32,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned NB_STATE     = NB_STATE_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cmd_valid_i,
  input  logic [NB_CMD-1:0]    cmd_i,
  output logic                 cmd_ready_o,
  input  logic                 halt_i,
  output logic                 pipe_en_o,
  output logic                 pipe_flush_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic [NB_STATE-1:0]  state_o,
  output logic [NB_CYCLES-1:0] cycle_count_o
);

  localparam int unsigned NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [NB_DRAIN-1:0] drain_q, drain_d;
  logic                flush_q, flush_d;
  logic                cmd_acc;

  // Every output is a decode of registered state; no input reaches an output.
  assign cmd_ready_o  = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_DONE);
  assign pipe_en_o    = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign busy_o       = pipe_en_o;
  assign done_o       = (state_q == ST_DONE);
  assign pipe_flush_o = flush_q;
  assign state_o      = NB_STATE'(state_q);
  assign cmd_acc      = cmd_valid_i && cmd_ready_o;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    flush_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc) begin
          if (cmd_i == NB_CMD'(CMD_RUN)) begin
            state_d = ST_RUN;
          end else if (cmd_i == NB_CMD'(CMD_STEP)) begin
            state_d = ST_STEP;
          end else if (cmd_i == NB_CMD'(CMD_FLUSH)) begin
            flush_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // HALT outranks a simultaneous STOP/FLUSH, which is then dropped.
        if (halt_i) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cmd_acc && (cmd_i == NB_CMD'(CMD_STOP))) begin
          state_d = ST_IDLE;
        end else if (cmd_acc && (cmd_i == NB_CMD'(CMD_FLUSH))) begin
          state_d = ST_IDLE;
          flush_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (halt_i) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - NB_DRAIN'(1);
        end
      end
      ST_DONE: begin
        if (cmd_acc && (cmd_i == NB_CMD'(CMD_FLUSH))) begin
          state_d = ST_IDLE;
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      flush_q <= flush_d;
    end
  end

`ifdef PIPE_CYCLE_COUNT_EN
  sat_counter #(
    .WIDTH (NB_CYCLES)
  ) u_cycle_cnt (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .en_i    (pipe_en_o),
    .clr_i   (flush_q),
    .count_o (cycle_count_o)
  );
`else
  assign cycle_count_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Scoreboard bench for pipeline_run_controller: directed commands push expected
// observations tagged with a cycle number; a negedge monitor pops and compares.
module tb_pipeline_run_controller;
  import pipeline_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic [1:0] cmd_i = 2'b00;
  logic       halt_i = 1'b0;
  logic       cmd_ready_o, pipe_en_o, pipe_flush_o, done_o, busy_o;
  logic [2:0] state_o;
  logic [3:0] cycle_count_o;

  pipeline_run_controller #(
    .NB_CMD       (2),
    .NB_CYCLES    (4),
    .DRAIN_CYCLES (4),
    .NB_STATE     (3)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_i         (cmd_i),
    .cmd_ready_o   (cmd_ready_o),
    .halt_i        (halt_i),
    .pipe_en_o     (pipe_en_o),
    .pipe_flush_o  (pipe_flush_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .state_o       (state_o),
    .cycle_count_o (cycle_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic       en;
    logic       fl;
    logic       dn;
    logic       bs;
    logic       rdy;
    logic [2:0] st;
    logic [3:0] cnt;
    logic [1:0] dr;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    string       name;
    obs_t        exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic obs_t mk(logic en, logic fl, logic dn, logic bs, logic rdy,
                              logic [2:0] st, logic [3:0] cnt, logic [1:0] dr);
    obs_t o;
    o.en = en; o.fl = fl; o.dn = dn; o.bs = bs; o.rdy = rdy; o.st = st; o.dr = dr;
`ifdef PIPE_CYCLE_COUNT_EN
    o.cnt = cnt;
`else
    o.cnt = 4'd0;
`endif
    return o;
  endfunction

  task automatic exp_at(input int unsigned c, input string nm, input obs_t o);
    exp_t e;
    e.cyc = c; e.name = nm; e.exp = o;
    sb.push_back(e);
  endtask

  task automatic go_to(input int unsigned c);
    while (cyc < c) @(negedge clk_i);
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  always @(negedge clk_i) begin
    obs_t act;
    exp_t e;
    act = {pipe_en_o, pipe_flush_o, done_o, busy_o, cmd_ready_o, state_o,
           cycle_count_o, dut.drain_q};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || act !== e.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d(due %0d) actual{en,fl,dn,bs,rdy,st,cnt,dr}=%b required=%b",
                 e.name, cyc, e.cyc, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //            en fl dn bs rdy st  cnt  dr
    @(negedge clk_i);
    exp_at(2, "reset_idle", mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 2'd0));
    go_to(2); reset_i = 1'b0;

    // RUN then STOP
    go_to(3);
    exp_at(4,  "run_en",    mk(1, 0, 0, 1, 1, 3'd1, 4'd0, 2'd0));
    exp_at(8,  "run_cnt",   mk(1, 0, 0, 1, 1, 3'd1, 4'd4, 2'd0));
    exp_at(12, "stop_idle", mk(0, 0, 0, 0, 1, 3'd0, 4'd8, 2'd0));
    cmd_valid_i = 1'b1; cmd_i = CMD_RUN;
    go_to(4);  cmd_valid_i = 1'b0;
    go_to(11); cmd_valid_i = 1'b1; cmd_i = CMD_STOP;
    go_to(12); cmd_valid_i = 1'b0;

    // FLUSH in IDLE
    go_to(13);
    exp_at(14, "idle_flush", mk(0, 1, 0, 0, 1, 3'd0, 4'd8, 2'd0));
    exp_at(15, "idle_clr",   mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 2'd0));
    cmd_valid_i = 1'b1; cmd_i = CMD_FLUSH;
    go_to(14); cmd_valid_i = 1'b0;

    // STEP
    go_to(16);
    exp_at(17, "step_en",   mk(1, 0, 0, 1, 0, 3'd2, 4'd0, 2'd0));
    exp_at(18, "step_idle", mk(0, 0, 0, 0, 1, 3'd0, 4'd1, 2'd0));
    cmd_valid_i = 1'b1; cmd_i = CMD_STEP;
    go_to(17); cmd_valid_i = 1'b0;

    // RUN, HALT -> DRAIN -> DONE, RUN ignored, FLUSH
    go_to(19);
    exp_at(20, "halt_run",    mk(1, 0, 0, 1, 1, 3'd1, 4'd1, 2'd0));
    exp_at(24, "drain_first", mk(1, 0, 0, 1, 0, 3'd3, 4'd5, 2'd3));
    exp_at(27, "drain_last",  mk(1, 0, 0, 1, 0, 3'd3, 4'd8, 2'd0));
    exp_at(28, "done",        mk(0, 0, 1, 0, 1, 3'd4, 4'd9, 2'd0));
    exp_at(30, "done_run",    mk(0, 0, 1, 0, 1, 3'd4, 4'd9, 2'd0));
    exp_at(32, "done_flush",  mk(0, 1, 0, 0, 1, 3'd0, 4'd9, 2'd0));
    exp_at(33, "done_clr",    mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 2'd0));
    cmd_valid_i = 1'b1; cmd_i = CMD_RUN;
    go_to(20); cmd_valid_i = 1'b0;
    go_to(23); halt_i = 1'b1;
    go_to(24); halt_i = 1'b0;
    go_to(29); cmd_valid_i = 1'b1; cmd_i = CMD_RUN;
    go_to(30); cmd_valid_i = 1'b0;
    go_to(31); cmd_valid_i = 1'b1; cmd_i = CMD_FLUSH;
    go_to(32); cmd_valid_i = 1'b0;

    // HALT together with STOP: halt wins
    go_to(34);
    exp_at(38, "hs_drain",  mk(1, 0, 0, 1, 0, 3'd3, 4'd3, 2'd3));
    exp_at(41, "hs_last",   mk(1, 0, 0, 1, 0, 3'd3, 4'd6, 2'd0));
    exp_at(42, "hs_done",   mk(0, 0, 1, 0, 1, 3'd4, 4'd7, 2'd0));
    exp_at(44, "hs_flush",  mk(0, 1, 0, 0, 1, 3'd0, 4'd7, 2'd0));
    exp_at(45, "hs_clr",    mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 2'd0));
    cmd_valid_i = 1'b1; cmd_i = CMD_RUN;
    go_to(35); cmd_valid_i = 1'b0;
    go_to(37); cmd_valid_i = 1'b1; cmd_i = CMD_STOP; halt_i = 1'b1;
    go_to(38); cmd_valid_i = 1'b0; halt_i = 1'b0;
    go_to(43); cmd_valid_i = 1'b1; cmd_i = CMD_FLUSH;
    go_to(44); cmd_valid_i = 1'b0;

    // Asynchronous reset in the middle of DRAIN
    go_to(46);
    exp_at(50, "rst_pre",   mk(1, 0, 0, 1, 0, 3'd3, 4'd3, 2'd2));
    exp_at(51, "rst_async", mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 2'd0));
    exp_at(53, "rst_after", mk(0, 0, 0, 0, 1, 3'd0, 4'd0, 2'd0));
    cmd_valid_i = 1'b1; cmd_i = CMD_RUN;
    go_to(47); cmd_valid_i = 1'b0;
    go_to(48); halt_i = 1'b1;
    go_to(49); halt_i = 1'b0;
    go_to(50);
    @(posedge clk_i); #2 reset_i = 1'b1;
    go_to(52); reset_i = 1'b0;

    // Counter saturation at 15 and clear on FLUSH
    go_to(54);
    exp_at(55, "sat_start", mk(1, 0, 0, 1, 1, 3'd1, 4'd0,  2'd0));
    exp_at(69, "sat_near",  mk(1, 0, 0, 1, 1, 3'd1, 4'd14, 2'd0));
    exp_at(74, "sat_hold",  mk(1, 0, 0, 1, 1, 3'd1, 4'd15, 2'd0));
    exp_at(75, "sat_stop",  mk(0, 0, 0, 0, 1, 3'd0, 4'd15, 2'd0));
    exp_at(77, "sat_flush", mk(0, 1, 0, 0, 1, 3'd0, 4'd15, 2'd0));
    exp_at(78, "sat_clr",   mk(0, 0, 0, 0, 1, 3'd0, 4'd0,  2'd0));
    cmd_valid_i = 1'b1; cmd_i = CMD_RUN;
    go_to(55); cmd_valid_i = 1'b0;
    go_to(74); cmd_valid_i = 1'b1; cmd_i = CMD_STOP;
    go_to(75); cmd_valid_i = 1'b0;
    go_to(76); cmd_valid_i = 1'b1; cmd_i = CMD_FLUSH;
    go_to(77); cmd_valid_i = 1'b0;

    go_to(80);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_i);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
Sequences the five-stage MIPS pipeline for the debug path. It accepts RUN, STEP, STOP and FLUSH commands over a valid/ready handshake and drives one global pipeline enable to the PC and every inter-stage latch. When a HALT instruction reaches ID, it lets the in-flight instructions drain, then parks in DONE. It sits between the debug command decoder and the datapath, alongside the hazard unit that freezes PC/IF_ID on HALT.

Parameters:
NB_CMD, 2, command code width
NB_CYCLES, 32, width of cycle counter
DRAIN_CYCLES, 4, enabled cycles after HALT detection before DONE (covers EX, MEM, WB plus one margin); must be >= 1
NB_STATE, 3, state encoding width

Ports:
clk_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous, active-high reset
cmd_valid_i  in  1  command present
cmd_i  in  NB_CMD  00 STOP, 01 RUN, 10 STEP, 11 FLUSH
cmd_ready_o  out  1  command accepted when valid&ready high on clock edge
halt_i  in  1  HALT instruction present in ID (same signal fed to hazard unit)
pipe_en_o  out  1  global enable for PC and all stage latches
pipe_flush_o  out  1  one-cycle synchronous clear of stage latches and PC
done_o  out  1  program finished, pipeline drained
busy_o  out  1  high in RUN, STEP, DRAIN
state_o  out  NB_STATE  current state, for debug readback
cycle_count_o  out  NB_CYCLES  enabled-cycle count (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-RUN or mid-DRAIN): state IDLE; pipe_en_o=0, pipe_flush_o=0, done_o=0, busy_o=0, cmd_ready_o=1, drain counter=0, cycle_count_o=0.
- All outputs are registered or decoded from the registered state only. There is no combinational path from inputs to outputs.
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4.
- cmd_ready_o=1 in IDLE, RUN and DONE; 0 in STEP and DRAIN.
- IDLE transitions on an accepted command:
  - RUN goes to RUN.
  - STEP goes to STEP.
  - FLUSH pulses pipe_flush_o in the next cycle, clears cycle count and stays IDLE.
  - STOP is a no-op.
- Enable latency: a command accepted at edge N gives pipe_en_o=1 from cycle N+1.
- RUN: pipe_en_o=1 every cycle.
  - halt_i=1 loads the drain counter with DRAIN_CYCLES-1 and goes to DRAIN.
  - Otherwise, STOP goes to IDLE and FLUSH goes to IDLE with a flush pulse.
  - RUN and STEP commands are accepted and discarded.
  - halt_i together with an accepted STOP or FLUSH: halt wins, DRAIN is entered and the command is discarded.
- STEP: pipe_en_o=1 for exactly one cycle. Next state is DRAIN if halt_i=1 in that cycle (counter loaded as above), else IDLE.
- DRAIN: pipe_en_o=1. The counter decrements each cycle. When the counter is 0, go to DONE; pipe_en_o falls in the first DONE cycle. halt_i is ignored in DRAIN.
- DONE: done_o=1, pipe_en_o=0.
  - Only FLUSH has effect: flush pulse, done_o cleared, go to IDLE.
  - STOP, RUN and STEP are accepted and discarded.
- pipe_flush_o is never high in the same cycle as pipe_en_o.
- busy_o is a decode of state (RUN | STEP | DRAIN).

Optional Feature:
- Macro PIPE_CYCLE_COUNT_EN.
- When defined: cycle_count_o increments by 1 on each clock with pipe_en_o=1 and saturates at all-ones. It clears on reset or on a FLUSH pulse and holds otherwise.
- When undefined: no counter register; cycle_count_o is tied to 0.

Decomposition:
- Shared package/header pipeline_ctrl_pkg holds:
  - state encodings (ST_IDLE..ST_DONE)
  - command codes (CMD_STOP, CMD_RUN, CMD_STEP, CMD_FLUSH)
  - default NB_CMD and NB_STATE
- One natural sub-module: sat_counter (parameterised width, enable, synchronous clear, async reset), used for the cycle counter. The drain down-counter stays inline.

Test Plan:
- Reset released, RUN accepted at edge 2 -> pipe_en_o=1 from cycle 3, busy_o=1, cmd_ready_o=1; STOP at edge 10 -> pipe_en_o=0 from cycle 11, state_o=0.
- STEP accepted at edge 2 -> pipe_en_o high for exactly cycle 3, cmd_ready_o=0 in cycle 3, back to IDLE in cycle 4; with the macro, cycle_count_o=1.
- RUN, then halt_i high at cycle 20 with DRAIN_CYCLES=4 -> pipe_en_o stays 1 through cycle 24, done_o=1 and pipe_en_o=0 at cycle 25; RUN in DONE -> no change; FLUSH -> pipe_flush_o pulse one cycle, done_o=0, IDLE.
- In RUN, halt_i and STOP asserted in the same cycle -> DRAIN entered, STOP discarded, DONE reached after 4 enabled cycles.
- reset_i asserted asynchronously mid-DRAIN (between edges) -> all outputs at reset values immediately, drain counter 0, state_o=0.
- Macro defined, NB_CYCLES=4, RUN for 20 cycles -> cycle_count_o saturates at 15; FLUSH -> 0. Macro undefined -> cycle_count_o=0 throughout.
